data_ram_resp: RTL

- Responder end of the MEM-stage data-memory interface: the MEM stage initiates load/store requests, and this block services them from an internal word-organised RAM.
- Completes each request after a programmable number of wait states and reports completion with a one-cycle ack.
- Sits beside the CPU core inside the SoC top, in the same way the instruction ROM serves the fetch side.

---
 rtl/data_ram_resp.sv | 127 ++++++++++++
 1 files changed

// File: rtl/data_ram_resp.sv
// Data-memory responder for the MEM stage: services load/store requests from a
// byte-lane RAM after a fixed number of wait states and signals completion with a one-cycle ack.
module data_ram_resp #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_ack,
  output logic        mem_err
);

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_ACK     = 2'd2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
  localparam bit         NO_WAIT   = (WAIT_STATES == 0);

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [31:0]       r_addr;
  logic [3:0]        r_sel;
  logic [31:0]       r_data;
  logic              r_ack;
  logic              r_err;
  logic [31:0]       r_data_o;

  logic              w_capture;
  logic              w_fire;
  logic              w_op_we;
  logic [31:0]       w_op_addr;
  logic [3:0]        w_op_sel;
  logic [31:0]       w_op_data;
  logic [ADDR_W-1:0] w_idx;
  logic              w_oor;
  logic [31:0]       w_rd_word;
  logic [3:0]        w_lane_we;
  logic              w_unused_addr;

  assign w_capture = (r_state == S_IDLE) && mem_ce;
  // w_fire marks the edge that enters ACK; that is where the RAM access happens.
  assign w_fire    = NO_WAIT ? w_capture : ((r_state == S_WAIT) && (r_cnt == 4'd1));

  // Without wait states the access shares the capture edge, so the live inputs are used.
  assign w_op_we   = NO_WAIT ? mem_we     : r_we;
  assign w_op_addr = NO_WAIT ? mem_addr   : r_addr;
  assign w_op_sel  = NO_WAIT ? mem_sel    : r_sel;
  assign w_op_data = NO_WAIT ? mem_data_i : r_data;

  assign w_idx         = w_op_addr[ADDR_W+1:2];
  assign w_oor         = |w_op_addr[31:ADDR_W+2];
  assign w_unused_addr = &{1'b0, w_op_addr[1:0]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_mem [DEPTH];

      assign w_lane_we[gi] = w_fire && w_op_we && !w_oor && w_op_sel[gi];

      always_ff @(posedge clk) begin
        if (w_lane_we[gi]) begin
          r_mem[w_idx] <= w_op_data[8*gi +: 8];
        end
      end

      assign w_rd_word[8*gi +: 8] = w_op_sel[gi] ? r_mem[w_idx] : 8'h00;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_we     <= 1'b0;
      r_addr   <= 32'd0;
      r_sel    <= 4'd0;
      r_data   <= 32'd0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_data_o <= 32'd0;
    end else begin
      r_ack <= w_fire;
      r_err <= w_fire && w_oor;
      if (w_fire && !w_op_we) begin
        r_data_o <= w_oor ? 32'd0 : w_rd_word;
      end
      case (r_state)
        S_IDLE: begin
          if (w_capture) begin
            r_we    <= mem_we;
            r_addr  <= mem_addr;
            r_sel   <= mem_sel;
            r_data  <= mem_data_i;
            r_cnt   <= WAIT_INIT;
            r_state <= NO_WAIT ? S_ACK : S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= S_ACK;
          end
        end
        S_ACK: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_data_o = r_data_o;
  assign mem_ack    = r_ack;
  assign mem_err    = r_err;

endmodule
